// File: rtl/wb_mux_arbiter.sv
// wb_mux_arbiter
//   Arbitrates two register-file write sources: A (ALU result) and B (memory
//   load). It drives a registered mux2_1 select and a registered write port.
//   A grant is combinational (same-cycle ready). The write it produces appears
//   on wr_* one cycle later.
//
// Ports
//   clk                    rising-edge clock
//   reset_n                asynchronous active-low reset
//   req_a, data_a, addr_a  ALU write request, data and destination register
//   gnt_a                  A accepted this cycle
//   req_b, data_b, addr_b  load write request, data and destination register
//   gnt_b                  B accepted this cycle
//   sel                    mux select of the last grant (0 = A, 1 = B)
//   wr_en                  register-file write strobe; never set for register $0
//   wr_addr, wr_data       write address and data of the last grant
//
// Configuration
//   WB_ARB_RR_EN  defined:   round-robin on contention; from IDLE, B wins.
//                 undefined: load priority. B wins on contention until it has
//                            won STARVE_LIMIT consecutive times while A waited.
//
// State  | meaning
// -------+-----------------------------------
// IDLE   | no grant in the previous cycle
// LAST_A | A granted in the previous cycle
// LAST_B | B granted in the previous cycle

module wb_mux_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_a,
    input  logic [31:0] data_a,
    input  logic [4:0]  addr_a,
    output logic        gnt_a,
    input  logic        req_b,
    input  logic [31:0] data_b,
    input  logic [4:0]  addr_b,
    output logic        gnt_b,
    output logic        sel,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAST_A = 2'd1,
        LAST_B = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        win_a, win_b;
    logic        sel_q;
    logic        wr_en_q;
    logic [4:0]  wr_addr_q;
    logic [31:0] wr_data_q;
    logic [4:0]  mux_addr;
    logic [31:0] mux_data;

`ifndef WB_ARB_RR_EN
    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);
    logic [3:0] streak_q, streak_d;
`endif

    // Arbitration decision
    always_comb begin
        win_a = 1'b0;
        win_b = 1'b0;
        if (req_a && req_b) begin
`ifdef WB_ARB_RR_EN
            if (state_q == LAST_B) win_a = 1'b1;
            else                   win_b = 1'b1;
`else
            if (streak_q == STREAK_MAX) win_a = 1'b1;
            else                        win_b = 1'b1;
`endif
        end else begin
            win_a = req_a;
            win_b = req_b;
        end
    end

    // Grants are forced low during reset so nothing is accepted while it is asserted.
    assign gnt_a = reset_n & win_a;
    assign gnt_b = reset_n & win_b;

    always_comb begin
        state_d = IDLE;
        if (win_a)      state_d = LAST_A;
        else if (win_b) state_d = LAST_B;
    end

`ifndef WB_ARB_RR_EN
    // The streak counts B wins while A is waiting.
    // The streak is nonzero only right after a B grant, so any B grant that
    // does not follow LAST_B starts a fresh streak at 1.
    always_comb begin
        streak_d = streak_q;
        if (!req_a || win_a) begin
            streak_d = 4'd0;
        end else if (win_b) begin
            if (streak_q == STREAK_MAX)  streak_d = streak_q;
            else if (state_q == LAST_B)  streak_d = streak_q + 4'd1;
            else                         streak_d = 4'd1;
        end
    end
`endif

    assign mux_addr = win_b ? addr_b : addr_a;
    assign mux_data = win_b ? data_b : data_a;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
`ifndef WB_ARB_RR_EN
            streak_q  <= 4'd0;
`endif
            sel_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 32'd0;
        end else begin
            state_q  <= state_d;
`ifndef WB_ARB_RR_EN
            streak_q <= streak_d;
`endif
            if (win_a || win_b) begin
                sel_q     <= win_b;
                wr_addr_q <= mux_addr;
                wr_data_q <= mux_data;
                // Writes to $0 are accepted but never strobed into the file.
                wr_en_q   <= (mux_addr != 5'd0);
            end else begin
                wr_en_q   <= 1'b0;
            end
        end
    end

    assign sel     = sel_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_wb_mux_arbiter.sv
// Directed bench for wb_mux_arbiter. Expected values are hand-derived and
// follow whichever arbitration build (WB_ARB_RR_EN) is compiled.

module tb_wb_mux_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_a, req_b;
    logic [31:0] data_a, data_b;
    logic [4:0]  addr_a, addr_b;
    logic        gnt_a, gnt_b;
    logic        sel, wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int n_cmp = 0;
    int n_err = 0;

    wb_mux_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req_a   (req_a),
        .data_a  (data_a),
        .addr_a  (addr_a),
        .gnt_a   (gnt_a),
        .req_b   (req_b),
        .data_b  (data_b),
        .addr_b  (addr_b),
        .gnt_b   (gnt_b),
        .sel     (sel),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic e_en, input logic e_sel,
                              input logic [4:0] e_addr, input logic [31:0] e_data);
        check_val({tag, ".wr_en"},   32'(wr_en),   32'(e_en));
        check_val({tag, ".sel"},     32'(sel),     32'(e_sel));
        check_val({tag, ".wr_addr"}, 32'(wr_addr), 32'(e_addr));
        check_val({tag, ".wr_data"}, wr_data,      e_data);
    endtask

    initial begin
        logic exp_b;

        reset_n = 1'b0;
        req_a = 1'b1; data_a = 32'd650; addr_a = 5'd3;
        req_b = 1'b0; data_b = 32'd0;   addr_b = 5'd0;
        #1;
        check_val("rst.gnt_a", 32'(gnt_a), 32'd0);
        check_regs("rst", 1'b0, 1'b0, 5'd0, 32'd0);
        req_a = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        // Single A request
        req_a = 1'b1; data_a = 32'd650; addr_a = 5'd3;
        #1;
        check_val("a_only.gnt_a", 32'(gnt_a), 32'd1);
        check_val("a_only.gnt_b", 32'(gnt_b), 32'd0);
        step();
        req_a = 1'b0;
        check_regs("a_only", 1'b1, 1'b0, 5'd3, 32'd650);
        step();
        check_val("a_only.pulse", 32'(wr_en), 32'd0);

        // B writes register $0
        req_b = 1'b1; data_b = 32'd150; addr_b = 5'd0;
        #1;
        check_val("b_r0.gnt_b", 32'(gnt_b), 32'd1);
        step();
        req_b = 1'b0;
        check_regs("b_r0", 1'b0, 1'b1, 5'd0, 32'd150);

        // B grant, then three idle cycles hold sel and data
        req_b = 1'b1; data_b = 32'd150; addr_b = 5'd4;
        #1;
        step();
        req_b = 1'b0;
        check_regs("b_r4", 1'b1, 1'b1, 5'd4, 32'd150);
        for (int i = 0; i < 3; i++) begin
            step();
            check_regs("idle_hold", 1'b0, 1'b1, 5'd4, 32'd150);
        end

        // Contention with both requests held
        req_a = 1'b1; data_a = 32'd650; addr_a = 5'd3;
        req_b = 1'b1; data_b = 32'd150; addr_b = 5'd4;
        for (int i = 0; i < 6; i++) begin
`ifdef WB_ARB_RR_EN
            exp_b = (i % 2 == 0);
`else
            exp_b = (i != 4);
`endif
            #1;
            check_val("cont.gnt_a", 32'(gnt_a), 32'(!exp_b));
            check_val("cont.gnt_b", 32'(gnt_b), 32'(exp_b));
            step();
            check_regs("cont", 1'b1, exp_b, exp_b ? 5'd4 : 5'd3,
                       exp_b ? 32'd150 : 32'd650);
        end
        req_a = 1'b0; req_b = 1'b0;
        step();
        check_val("cont.end_en", 32'(wr_en), 32'd0);

        // Same destination from both sides: the loser's write lands later
        req_a = 1'b1; data_a = 32'd111; addr_a = 5'd5;
        req_b = 1'b1; data_b = 32'd222; addr_b = 5'd5;
        #1;
        check_val("same.gnt_b", 32'(gnt_b), 32'd1);
        check_val("same.gnt_a", 32'(gnt_a), 32'd0);
        step();
        req_b = 1'b0;
        check_regs("same.first", 1'b1, 1'b1, 5'd5, 32'd222);
        #1;
        check_val("same.gnt_a2", 32'(gnt_a), 32'd1);
        step();
        req_a = 1'b0;
        check_regs("same.second", 1'b1, 1'b0, 5'd5, 32'd111);

        // Reset asserted mid-grant
        req_a = 1'b1; data_a = 32'd650; addr_a = 5'd3;
        #1;
        check_val("midrst.gnt_pre", 32'(gnt_a), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_val("midrst.gnt_a", 32'(gnt_a), 32'd0);
        check_regs("midrst", 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        check_val("midrst.hold_en", 32'(wr_en), 32'd0);
        #2 reset_n = 1'b1;
        #1;
        check_val("midrst.regnt", 32'(gnt_a), 32'd1);
        step();
        req_a = 1'b0;
        check_regs("midrst.after", 1'b1, 1'b0, 5'd3, 32'd650);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
